// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate inverse block.
// Holds the controller state encoding and the default operand width.
package mac_pkg;

    localparam int DATA_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_inverse_if.sv
// Request/response bundle for mac_inverse.
// The slave modport is the divider; the master modport is its requester and consumer.
interface mac_inverse_if #(
    parameter int DATA_WIDTH = mac_pkg::DATA_WIDTH_DEFAULT
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] y;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] c;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] r;
    logic                  div0;

    modport slave (
        input  in_valid, y, b, c, out_ready,
        output in_ready, out_valid, q, r, div0
    );

    modport master (
        output in_valid, y, b, c, out_ready,
        input  in_ready, out_valid, q, r, div0
    );
endinterface

// File: rtl/mac_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mac_div_step
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic                  bit_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  q_bit
);
    logic [DATA_WIDTH-1:0] shifted_low;

    // The shifted value is W+1 bits; a set top bit always exceeds any W-bit
    // divisor, and the true difference is below the divisor so W bits suffice.
    always_comb begin
        shifted_low = {rem_in[DATA_WIDTH-2:0], bit_in};
        q_bit       = rem_in[DATA_WIDTH-1] || (shifted_low >= divisor);
        rem_out     = q_bit ? (shifted_low - divisor) : shifted_low;
    end
endmodule

// File: rtl/mac_inverse.sv
// Unwinds y = a*b + c: forms d = y - c (mod 2^W) and divides by b with a
// fixed-latency restoring divider, W steps regardless of operands.
module mac_inverse
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mac_inverse_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  div0_q, div0_d;

    logic [DATA_WIDTH-1:0] step_rem;
    logic                  step_qbit;
    logic                  in_ready_c;
    logic                  out_valid_c;

    mac_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (d_q[cnt_q]),
        .divisor (b_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        b_d         = b_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        cnt_d       = cnt_q;
        div0_d      = div0_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    d_d     = bus.y - bus.c;
                    b_d     = bus.b;
                    rem_d   = '0;
                    quot_d  = '0;
                    cnt_d   = CNT_W'(DATA_WIDTH - 1);
                    div0_d  = (bus.b == '0);
                    state_d = DIV;
                end
            end
            DIV: begin
                // With b = 0 every step sets its quotient bit and keeps the
                // shifted bits, so q ends all ones and r ends equal to d.
                rem_d  = step_rem;
                quot_d = {quot_q[DATA_WIDTH-2:0], step_qbit};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            div0_q  <= div0_d;
        end
    end

    // Operand holding registers are reloaded on every accept and need no reset.
    always_ff @(posedge clk) begin
        d_q <= d_d;
        b_q <= b_d;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.q         = quot_q;
    assign bus.r         = rem_q;
    assign bus.div0      = div0_q;
endmodule

// File: tb/tb_mac_inverse.sv
// Directed and round-trip bench for mac_inverse at W = 4.
module tb_mac_inverse;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mac_inverse_if #(.DATA_WIDTH(W)) bus ();

    mac_inverse #(
        .DATA_WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] mac_4(input int a, input int bb, input int cc);
        return 4'((a * bb + cc) % 16);
    endfunction

    // Issue one request, check the fixed latency, capture the result, release it.
    task automatic do_op(input string tag, input logic [3:0] yv, input logic [3:0] cv,
                         input logic [3:0] bv, output logic [3:0] qo,
                         output logic [3:0] ro, output logic d0o);
        bus.y        = yv;
        bus.c        = cv;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 1; i < W; i++) begin
            tick();
            check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
        end
        tick();
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        qo  = bus.q;
        ro  = bus.r;
        d0o = bus.div0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] qv;
        logic [3:0] rv;
        logic       dv;
        logic       any_valid;
        int         a, bb, cc;
        logic [3:0] yy;

        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.y         = '0;
        bus.b         = '0;
        bus.c         = '0;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_r", 32'(bus.r), 32'd0);
        check("rst_div0", 32'(bus.div0), 32'd0);
        rst = 1'b0;
        tick();

        // Basic: d = 8, 8 / 3 = 2 rem 2
        do_op("basic", 4'd11, 4'd3, 4'd3, qv, rv, dv);
        check("basic_q", 32'(qv), 32'd2);
        check("basic_r", 32'(rv), 32'd2);
        check("basic_div0", 32'(dv), 32'd0);
        check("basic_idle_ready", 32'(bus.in_ready), 32'd1);
        check("basic_idle_valid", 32'(bus.out_valid), 32'd0);

        // Wrap: d = (2 - 5) mod 16 = 13, 13 / 4 = 3 rem 1
        do_op("wrap", 4'd2, 4'd5, 4'd4, qv, rv, dv);
        check("wrap_q", 32'(qv), 32'd3);
        check("wrap_r", 32'(rv), 32'd1);
        check("wrap_div0", 32'(dv), 32'd0);

        // Divide by zero: d = 4
        do_op("div0", 4'd5, 4'd1, 4'd0, qv, rv, dv);
        check("div0_q", 32'(qv), 32'd15);
        check("div0_r", 32'(rv), 32'd4);
        check("div0_flag", 32'(dv), 32'd1);

        // Backpressure: d = 14, 14 / 5 = 2 rem 4, held for 3 cycles
        bus.y        = 4'd14;
        bus.c        = 4'd0;
        bus.b        = 4'd5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("bp_busy_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < W; i++) tick();
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.y        = 4'd7;
            bus.b        = 4'd1;
            tick();
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold_q", 32'(bus.q), 32'd2);
            check("bp_hold_r", 32'(bus.r), 32'd4);
            check("bp_hold_div0", 32'(bus.div0), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);

        // Reset abort during the second DIV cycle
        bus.y        = 4'd9;
        bus.c        = 4'd0;
        bus.b        = 4'd2;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", 32'(bus.in_ready), 32'd1);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_q", 32'(bus.q), 32'd0);
        any_valid = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            any_valid = any_valid | bus.out_valid;
        end
        check("abort_no_pulse", 32'(any_valid), 32'd0);
        do_op("after_abort", 4'd9, 4'd0, 4'd2, qv, rv, dv);
        check("after_abort_q", 32'(qv), 32'd4);
        check("after_abort_r", 32'(rv), 32'd1);
        check("after_abort_div0", 32'(dv), 32'd0);

        // Round trip through the forward MAC model
        for (int n = 0; n < 1000; n++) begin
            a  = int'($urandom_range(0, 15));
            bb = int'($urandom_range(1, 15));
            cc = int'($urandom_range(0, 15));
            yy = mac_4(a, bb, cc);
            do_op("rt", yy, 4'(cc), 4'(bb), qv, rv, dv);
            check("rt_identity", 32'(mac_4(int'(qv), bb, int'(rv) + cc)), 32'(yy));
            if ((a * bb + cc < 16) && (cc < bb)) begin
                check("rt_q_eq_a", 32'(qv), 32'(a));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
